// File: rtl/sbox_share_arbiter_if.sv
// Request/response bundle between the two S-box users (round datapath, key schedule)
// and the shared 4-sbox column unit.
interface sbox_share_arbiter_if;
    logic         st_req_valid;
    logic         st_req_ready;
    logic [127:0] st_in;
    logic         st_out_valid;
    logic [127:0] st_out;
    logic         kw_req_valid;
    logic         kw_req_ready;
    logic [31:0]  kw_in;
    logic         kw_out_valid;
    logic [31:0]  kw_out;

    modport master (
        output st_req_valid, st_in, kw_req_valid, kw_in,
        input  st_req_ready, st_out_valid, st_out, kw_req_ready, kw_out_valid, kw_out
    );

    modport slave (
        input  st_req_valid, st_in, kw_req_valid, kw_in,
        output st_req_ready, st_out_valid, st_out, kw_req_ready, kw_out_valid, kw_out
    );
endinterface

// File: rtl/sbox_share_arbiter.sv
// Schedules one 4-byte AES S-box column unit between SubBytes (4 columns, one per
// cycle) and key-expansion SubWord (one word), with selectable arbitration policy.
module sbox_share_arbiter #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    sbox_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ST_RUN, KW_RUN} state_t;

    localparam logic GRANT_ST = 1'b0;
    localparam logic GRANT_KW = 1'b1;

    // Index 0 sits at the MSB end of the concatenation.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[x];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    state_t       state, state_nxt;
    logic [1:0]   col_cnt;
    logic         last_grant;
    logic [127:0] st_op_p0;
    logic [31:0]  kw_op_p0;
    logic [127:0] st_out_p1;
    logic [31:0]  kw_out_p1;
    logic         vld_st_p1;
    logic         vld_kw_p1;

    logic         prefer_st;
    logic         contested;
    logic         st_ready;
    logic         kw_ready;
    logic         grant_st;
    logic         grant_kw;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;

    always_comb begin
        if (PRIORITY_MODE == 1) begin
            prefer_st = 1'b1;
        end else if (PRIORITY_MODE == 2) begin
            prefer_st = 1'b0;
        end else begin
            prefer_st = (last_grant == GRANT_KW);
        end
    end

    assign contested = bus.st_req_valid && bus.kw_req_valid;

    // The loser of a contested cycle sees ready low so its valid is not consumed.
    always_comb begin
        state_nxt = state;
        st_ready  = 1'b0;
        kw_ready  = 1'b0;
        grant_st  = 1'b0;
        grant_kw  = 1'b0;
        sb_in     = '0;
        case (state)
            IDLE: begin
                st_ready = !(contested && !prefer_st);
                kw_ready = !(contested && prefer_st);
                grant_st = bus.st_req_valid && st_ready;
                grant_kw = bus.kw_req_valid && kw_ready;
                if (grant_st) begin
                    state_nxt = ST_RUN;
                end else if (grant_kw) begin
                    state_nxt = KW_RUN;
                end
            end
            ST_RUN: begin
                case (col_cnt)
                    2'd0:    sb_in = st_op_p0[127:96];
                    2'd1:    sb_in = st_op_p0[95:64];
                    2'd2:    sb_in = st_op_p0[63:32];
                    default: sb_in = st_op_p0[31:0];
                endcase
                if (col_cnt == 2'd3) begin
                    state_nxt = IDLE;
                end
            end
            KW_RUN: begin
                sb_in     = kw_op_p0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sb_out = sub_word(sb_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: operand capture on handshake; stage p1: substituted results and pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt    <= 2'd0;
            last_grant <= GRANT_KW;
            st_op_p0   <= '0;
            kw_op_p0   <= '0;
            st_out_p1  <= '0;
            kw_out_p1  <= '0;
            vld_st_p1  <= 1'b0;
            vld_kw_p1  <= 1'b0;
        end else begin
            vld_st_p1 <= 1'b0;
            vld_kw_p1 <= 1'b0;
            if (grant_st) begin
                st_op_p0   <= bus.st_in;
                col_cnt    <= 2'd0;
                last_grant <= GRANT_ST;
            end
            if (grant_kw) begin
                kw_op_p0   <= bus.kw_in;
                last_grant <= GRANT_KW;
            end
            if (state == ST_RUN) begin
                case (col_cnt)
                    2'd0:    st_out_p1[127:96] <= sb_out;
                    2'd1:    st_out_p1[95:64]  <= sb_out;
                    2'd2:    st_out_p1[63:32]  <= sb_out;
                    default: st_out_p1[31:0]   <= sb_out;
                endcase
                if (col_cnt == 2'd3) begin
                    col_cnt   <= 2'd0;
                    vld_st_p1 <= 1'b1;
                end else begin
                    col_cnt <= col_cnt + 2'd1;
                end
            end
            if (state == KW_RUN) begin
                kw_out_p1 <= sb_out;
                vld_kw_p1 <= 1'b1;
            end
        end
    end

    assign bus.st_req_ready = st_ready;
    assign bus.kw_req_ready = kw_ready;
    assign bus.st_out_valid = vld_st_p1;
    assign bus.st_out       = st_out_p1;
    assign bus.kw_out_valid = vld_kw_p1;
    assign bus.kw_out       = kw_out_p1;
endmodule

// File: tb/tb_sbox_share_arbiter.sv
// Directed bench for sbox_share_arbiter: latency, substitution values, arbitration
// in all three priority modes, blocking during a run, and mid-operation reset.
module tb_sbox_share_arbiter;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sbox_share_arbiter_if b0();
    sbox_share_arbiter_if b1();
    sbox_share_arbiter_if b2();

    sbox_share_arbiter #(.PRIORITY_MODE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    sbox_share_arbiter #(.PRIORITY_MODE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    sbox_share_arbiter #(.PRIORITY_MODE(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    localparam logic [127:0] ST_ZERO_IN  = 128'h0;
    localparam logic [127:0] ST_ZERO_EXP = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ST_SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ST_SEQ_EXP  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ST_FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ST_FIPS_EXP = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [31:0]  KW_IN       = 32'h00010203;
    localparam logic [31:0]  KW_EXP      = 32'h637c777b;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        b0.st_req_valid = 1'b0; b0.st_in = '0; b0.kw_req_valid = 1'b0; b0.kw_in = '0;
        b1.st_req_valid = 1'b0; b1.st_in = '0; b1.kw_req_valid = 1'b0; b1.kw_in = '0;
        b2.st_req_valid = 1'b0; b2.st_in = '0; b2.kw_req_valid = 1'b0; b2.kw_in = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        #1;
    endtask

    task automatic run_st(input string tag, input logic [127:0] din, input logic [127:0] exp);
        b0.st_req_valid = 1'b1;
        b0.st_in        = din;
        #1;
        check({tag, "_accept_ready"}, 128'(b0.st_req_ready), 128'd1);
        tick;
        b0.st_req_valid = 1'b0;
        b0.st_in        = ~din;
        #1;
        check({tag, "_busy_ready"}, 128'(b0.st_req_ready), 128'd0);
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_early_valid"}, 128'(b0.st_out_valid), 128'd0);
            tick;
        end
        check({tag, "_valid"}, 128'(b0.st_out_valid), 128'd1);
        check({tag, "_data"}, b0.st_out, exp);
        tick;
        check({tag, "_pulse_end"}, 128'(b0.st_out_valid), 128'd0);
        check({tag, "_hold"}, b0.st_out, exp);
    endtask

    task automatic run_kw(input string tag, input logic [31:0] din, input logic [31:0] exp);
        b0.kw_req_valid = 1'b1;
        b0.kw_in        = din;
        #1;
        check({tag, "_accept_ready"}, 128'(b0.kw_req_ready), 128'd1);
        tick;
        b0.kw_req_valid = 1'b0;
        b0.kw_in        = ~din;
        check({tag, "_early_valid"}, 128'(b0.kw_out_valid), 128'd0);
        tick;
        check({tag, "_valid"}, 128'(b0.kw_out_valid), 128'd1);
        check({tag, "_data"}, 128'(b0.kw_out), 128'(exp));
        tick;
        check({tag, "_pulse_end"}, 128'(b0.kw_out_valid), 128'd0);
    endtask

    initial begin
        int m1_st_grants, m1_kw_ready, m1_st_pulses, m1_kw_pulses;
        int m2_kw_grants, m2_st_ready, m2_kw_pulses, m2_st_pulses;
        int late_pulses;

        reset = 1'b1;
        clear_inputs();
        tick;
        do_reset();

        check("rst_st_ready", 128'(b0.st_req_ready), 128'd1);
        check("rst_kw_ready", 128'(b0.kw_req_ready), 128'd1);
        check("rst_st_valid", 128'(b0.st_out_valid), 128'd0);
        check("rst_kw_valid", 128'(b0.kw_out_valid), 128'd0);
        check("rst_st_out", b0.st_out, 128'd0);
        check("rst_kw_out", 128'(b0.kw_out), 128'd0);

        run_st("st_zero", ST_ZERO_IN, ST_ZERO_EXP);
        run_kw("kw_word", KW_IN, KW_EXP);
        run_st("st_seq", ST_SEQ_IN, ST_SEQ_EXP);

        // Key request arrives mid state-run and must wait for IDLE.
        b0.st_req_valid = 1'b1;
        b0.st_in        = ST_FIPS_IN;
        tick;
        b0.st_req_valid = 1'b0;
        tick;
        b0.kw_req_valid = 1'b1;
        b0.kw_in        = KW_IN;
        for (int k = 2; k <= 4; k++) begin
            #1;
            check("blk_kw_ready_low", 128'(b0.kw_req_ready), 128'd0);
            tick;
        end
        #1;
        check("blk_kw_ready_idle", 128'(b0.kw_req_ready), 128'd1);
        check("blk_st_valid", 128'(b0.st_out_valid), 128'd1);
        check("blk_st_data", b0.st_out, ST_FIPS_EXP);
        tick;
        b0.kw_req_valid = 1'b0;
        check("blk_kw_early", 128'(b0.kw_out_valid), 128'd0);
        tick;
        check("blk_kw_valid", 128'(b0.kw_out_valid), 128'd1);
        check("blk_kw_data", 128'(b0.kw_out), 128'(KW_EXP));
        check("blk_st_unaffected", b0.st_out, ST_FIPS_EXP);

        // Round-robin: both held valid from reset -> state, key, state.
        do_reset();
        b0.st_req_valid = 1'b1;
        b0.st_in        = ST_FIPS_IN;
        b0.kw_req_valid = 1'b1;
        b0.kw_in        = KW_IN;
        #1;
        check("rr_first_st_ready", 128'(b0.st_req_ready), 128'd1);
        check("rr_first_kw_ready", 128'(b0.kw_req_ready), 128'd0);
        tick;
        check("rr_run_kw_ready", 128'(b0.kw_req_ready), 128'd0);
        repeat (4) tick;
        check("rr_st_valid", 128'(b0.st_out_valid), 128'd1);
        check("rr_st_data", b0.st_out, ST_FIPS_EXP);
        check("rr_second_kw_ready", 128'(b0.kw_req_ready), 128'd1);
        check("rr_second_st_ready", 128'(b0.st_req_ready), 128'd0);
        tick;
        tick;
        check("rr_kw_valid", 128'(b0.kw_out_valid), 128'd1);
        check("rr_kw_data", 128'(b0.kw_out), 128'(KW_EXP));
        check("rr_third_st_ready", 128'(b0.st_req_ready), 128'd1);
        check("rr_third_kw_ready", 128'(b0.kw_req_ready), 128'd0);
        tick;
        b0.st_req_valid = 1'b0;
        b0.kw_req_valid = 1'b0;
        repeat (4) tick;
        check("rr_third_st_valid", 128'(b0.st_out_valid), 128'd1);
        tick;

        // Fixed priority: continuous contention over 15 cycles.
        m1_st_grants = 0; m1_kw_ready = 0; m1_st_pulses = 0; m1_kw_pulses = 0;
        m2_kw_grants = 0; m2_st_ready = 0; m2_kw_pulses = 0; m2_st_pulses = 0;
        b1.st_req_valid = 1'b1; b1.kw_req_valid = 1'b1;
        b2.st_req_valid = 1'b1; b2.kw_req_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            #1;
            m1_st_grants += int'(b1.st_req_valid && b1.st_req_ready);
            m1_kw_ready  += int'(b1.kw_req_ready);
            m1_st_pulses += int'(b1.st_out_valid);
            m1_kw_pulses += int'(b1.kw_out_valid);
            m2_kw_grants += int'(b2.kw_req_valid && b2.kw_req_ready);
            m2_st_ready  += int'(b2.st_req_ready);
            m2_kw_pulses += int'(b2.kw_out_valid);
            m2_st_pulses += int'(b2.st_out_valid);
            tick;
        end
        clear_inputs();
        check("m1_st_grants", 128'(m1_st_grants), 128'd3);
        check("m1_kw_ready_cycles", 128'(m1_kw_ready), 128'd0);
        check("m1_st_pulses", 128'(m1_st_pulses), 128'd2);
        check("m1_kw_pulses", 128'(m1_kw_pulses), 128'd0);
        check("m1_st_data", b1.st_out, ST_ZERO_EXP);
        check("m2_kw_grants", 128'(m2_kw_grants), 128'd8);
        check("m2_st_ready_cycles", 128'(m2_st_ready), 128'd0);
        check("m2_kw_pulses", 128'(m2_kw_pulses), 128'd7);
        check("m2_st_pulses", 128'(m2_st_pulses), 128'd0);
        check("m2_kw_data", 128'(b2.kw_out), 128'h63636363);
        repeat (3) tick;

        // Reset in T+3 of a state operation aborts it silently.
        b0.st_req_valid = 1'b1;
        b0.st_in        = ST_SEQ_IN;
        tick;
        b0.st_req_valid = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        #1;
        check("abort_st_out_now", b0.st_out, 128'd0);
        check("abort_st_valid_now", 128'(b0.st_out_valid), 128'd0);
        tick;
        tick;
        reset = 1'b0;
        #1;
        check("abort_st_ready", 128'(b0.st_req_ready), 128'd1);
        check("abort_kw_ready", 128'(b0.kw_req_ready), 128'd1);
        late_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            late_pulses += int'(b0.st_out_valid);
            tick;
        end
        check("abort_no_pulse", 128'(late_pulses), 128'd0);
        check("abort_st_out", b0.st_out, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
